// File: rtl/tank_fill_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tank_fill_controller                                             |
// | Brief   : Debounced tank level supervisor: pump fill cycle with hysteresis,|
// |           minimum run time, fill timeout, fault handling and alarm LED.    |
// |           Define ALARM_LATCH_EN to latch alarm_on until a clean alarm_ack. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tank_fill_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_PUMP_CYCLES = 16,
  parameter int MAX_FILL_CYCLES = 1024,
  parameter int CNT_W           = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_low,
  input  logic       sensor_mid,
  input  logic       sensor_high,
  input  logic       enable,
  input  logic       alarm_ack,
  output logic       pump_on,
  output logic       alarm_on,
  output logic       fault,
  output logic [1:0] state
);

  localparam logic [1:0] c_IDLE      = 2'b00;
  localparam logic [1:0] c_FILLING   = 2'b01;
  localparam logic [1:0] c_FULL_HOLD = 2'b10;
  localparam logic [1:0] c_FAULT     = 2'b11;

  localparam int               c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_MIN_M1  = CNT_W'(MIN_PUMP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_FILL_M1 = CNT_W'(MAX_FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_CNT_SAT = '1;

  logic [2:0]       w_raw;
  logic [2:0]       w_db;
  logic             w_low_db;
  logic             w_mid_db;
  logic             w_high_db;
  logic             w_conflict;
  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_pump_cnt;
  logic [CNT_W-1:0] r_fill_cnt;
  logic             w_fill_start;
  logic             w_pump_d;
  logic             w_fault_d;
  logic             w_cause;
  logic             w_alarm_d;

  assign w_raw = {sensor_high, sensor_mid, sensor_low};

  // Each sensor's debounced level moves only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
      logic [c_DB_W-1:0] r_cnt;
      logic              r_level;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (w_raw[gi] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_cnt   <= '0;
          r_level <= w_raw[gi];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_db[gi] = r_level;
    end
  endgenerate

  assign w_low_db   = w_db[0];
  assign w_mid_db   = w_db[1];
  assign w_high_db  = w_db[2];
  assign w_conflict = (w_high_db & ~w_mid_db) | (w_mid_db & ~w_low_db) | (w_high_db & ~w_low_db);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_conflict) begin
          w_state_next = c_FAULT;
        end else if (enable && !w_mid_db) begin
          w_state_next = c_FILLING;
        end
      end
      c_FILLING: begin
        if (w_conflict) begin
          w_state_next = c_FAULT;
        end else if (r_fill_cnt == c_FILL_M1) begin
          w_state_next = c_FAULT;
        end else if (w_high_db && (r_pump_cnt >= c_MIN_M1)) begin
          w_state_next = c_FULL_HOLD;
        end else if (!enable && (r_pump_cnt >= c_MIN_M1)) begin
          w_state_next = c_IDLE;
        end
      end
      c_FULL_HOLD: begin
        if (w_conflict) begin
          w_state_next = c_FAULT;
        end else if (!enable) begin
          w_state_next = c_IDLE;
        end else if (!w_mid_db) begin
          w_state_next = c_FILLING;
        end
      end
      default: begin
        if (alarm_ack && !w_conflict) begin
          w_state_next = c_IDLE;
        end
      end
    endcase
  end

  // Counters restart on every entry into FILLING, including refills from FULL_HOLD.
  assign w_fill_start = (r_state != c_FILLING) && (w_state_next == c_FILLING);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pump_cnt <= '0;
      r_fill_cnt <= '0;
    end else if (w_fill_start) begin
      r_pump_cnt <= '0;
      r_fill_cnt <= '0;
    end else if (r_state == c_FILLING) begin
      if (r_pump_cnt != c_CNT_SAT) begin
        r_pump_cnt <= r_pump_cnt + 1'b1;
      end
      if (r_fill_cnt != c_CNT_SAT) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_pump_d  = (r_state == c_FILLING);
    w_fault_d = (r_state == c_FAULT);
    w_cause   = w_conflict | ~w_low_db | w_fault_d;
`ifdef ALARM_LATCH_EN
    w_alarm_d = w_cause | (alarm_on & ~alarm_ack);
`else
    w_alarm_d = w_cause;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pump_on  <= 1'b0;
      alarm_on <= 1'b0;
      fault    <= 1'b0;
    end else begin
      pump_on  <= w_pump_d;
      alarm_on <= w_alarm_d;
      fault    <= w_fault_d;
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tank_fill_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tank_fill_controller                                          |
// | Brief   : Directed self-checking bench for tank_fill_controller.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tank_fill_controller;

`ifdef ALARM_LATCH_EN
  localparam logic c_LATCH = 1'b1;
`else
  localparam logic c_LATCH = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       sensor_low;
  logic       sensor_mid;
  logic       sensor_high;
  logic       enable;
  logic       alarm_ack;
  logic       pump_on;
  logic       alarm_on;
  logic       fault;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  tank_fill_controller #(
    .DEBOUNCE_CYCLES(4),
    .MIN_PUMP_CYCLES(16),
    .MAX_FILL_CYCLES(64),
    .CNT_W          (11)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sensor_low (sensor_low),
    .sensor_mid (sensor_mid),
    .sensor_high(sensor_high),
    .enable     (enable),
    .alarm_ack  (alarm_ack),
    .pump_on    (pump_on),
    .alarm_on   (alarm_on),
    .fault      (fault),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on falling edges; step(n) spans n rising edges.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sensor_low = 1'b0; sensor_mid = 1'b0; sensor_high = 1'b0;
    enable = 1'b0; alarm_ack = 1'b0;
    step(2);
    chk("rst_state", state, 2'b00);
    chk("rst_pump", pump_on, 1'b0);
    chk("rst_alarm", alarm_on, 1'b0);
    chk("rst_fault", fault, 1'b0);

    reset_n = 1'b1;
    step(1);
    chk("dry_alarm", alarm_on, 1'b1);
    chk("dry_idle", state, 2'b00);

    // Low sensor wets: alarm clears one edge after the debounced level updates.
    sensor_low = 1'b1;
    step(4);
    chk("low_db_alarm_hold", alarm_on, 1'b1);
    step(1);
    chk("low_db_alarm_clr", alarm_on, 1'b0);

    enable = 1'b1;
    step(1);
    chk("fill_state", state, 2'b01);
    chk("fill_pump_lag", pump_on, 1'b0);
    step(1);
    chk("fill_pump", pump_on, 1'b1);

    // Tank reaches high early; minimum run time holds the pump until pump_cnt=15.
    sensor_mid = 1'b1; sensor_high = 1'b1;
    step(14);
    chk("minrun_state", state, 2'b01);
    chk("minrun_pump", pump_on, 1'b1);
    step(1);
    chk("hold_state", state, 2'b10);
    step(1);
    chk("hold_pump_off", pump_on, 1'b0);

    // Hysteresis: losing high alone keeps FULL_HOLD; losing mid restarts filling.
    sensor_high = 1'b0;
    step(6);
    chk("hyst_hold", state, 2'b10);
    sensor_mid = 1'b0;
    step(4);
    chk("refill_wait", state, 2'b10);
    step(1);
    chk("refill_state", state, 2'b01);

    // Three-cycle high glitch (would be a conflict) must not reach the debounced level.
    sensor_high = 1'b1;
    step(3);
    sensor_high = 1'b0;
    step(3);
    chk("glitch_state", state, 2'b01);
    chk("glitch_fault", fault, 1'b0);

    // Timeout: FAULT on the edge after fill_cnt reaches 63.
    step(57);
    chk("tmo_pre_state", state, 2'b01);
    step(1);
    chk("tmo_state", state, 2'b11);
    step(1);
    chk("tmo_fault", fault, 1'b1);
    chk("tmo_pump", pump_on, 1'b0);
    chk("tmo_alarm", alarm_on, 1'b1);

    enable = 1'b0;
    ack_pulse();
    chk("tmo_ack_state", state, 2'b00);
    step(1);
    chk("tmo_ack_fault", fault, 1'b0);
    chk("tmo_ack_alarm", alarm_on, c_LATCH);

    // Conflict fault: high without mid.
    sensor_high = 1'b1;
    step(4);
    chk("cfl_wait", state, 2'b00);
    step(1);
    chk("cfl_state", state, 2'b11);
    chk("cfl_alarm", alarm_on, 1'b1);
    step(1);
    chk("cfl_fault", fault, 1'b1);
    ack_pulse();
    chk("cfl_ack_ignored", state, 2'b11);
    sensor_high = 1'b0;
    step(5);
    chk("cfl_fixed_hold", state, 2'b11);
    ack_pulse();
    chk("cfl_ack_exit", state, 2'b00);

    // Ack in IDLE with no cause clears any latched alarm and does nothing else.
    step(2);
    ack_pulse();
    chk("idle_ack_state", state, 2'b00);
    chk("idle_ack_alarm", alarm_on, 1'b0);

    // Low drops then recovers.
    sensor_low = 1'b0;
    step(4);
    chk("lowdrop_wait", alarm_on, 1'b0);
    step(1);
    chk("lowdrop_alarm", alarm_on, 1'b1);
    sensor_low = 1'b1;
    step(5);
    chk("lowrec_alarm", alarm_on, c_LATCH);
    ack_pulse();
    chk("lowrec_ack_alarm", alarm_on, 1'b0);

    // Reset in the middle of a fill.
    enable = 1'b1;
    step(1);
    chk("rf_state", state, 2'b01);
    step(1);
    chk("rf_pump", pump_on, 1'b1);
    #2;
    reset_n = 1'b0;
    enable = 1'b0; sensor_low = 1'b0; sensor_mid = 1'b0; sensor_high = 1'b0;
    #1;
    chk("rf_async_pump", pump_on, 1'b0);
    chk("rf_async_state", state, 2'b00);
    step(1);
    reset_n = 1'b1;
    step(1);
    chk("rf_rel_alarm", alarm_on, 1'b1);
    chk("rf_rel_state", state, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
